frame_buffer_reader: RTL
========================

# frame_buffer_reader

Read-side master for the inferred dual-port frame RAM. On a `start` pulse it walks one full frame of RAM addresses in raster order, absorbs the RAM's one-cycle registered read latency, and delivers pixels on a valid/ready stream. Line and frame markers go with each pixel. It sits between the frame RAM read port and the video output / encoder stage; the write side of the RAM is owned elsewhere.

## Interface
- `RAM_DATA_WIDTH`, 15, pixel / RAM word width.
- `RAM_ADDR_WIDTH`, 16, RAM address width.
- `LINE_WORDS`, 256, pixels per line (≥2).
- `LINE_COUNT`, 240, lines per frame (≥1). LINE_WORDS*LINE_COUNT ≤ 2**RAM_ADDR_WIDTH.
- `BASE_ADDR`, 0, RAM address of pixel (0,0).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to read one frame.
- `busy` out 1: high from the cycle after an accepted `start` through the cycle `done` is high.
- `done` out 1: one-cycle pulse after the last pixel handshake.
- `read_addr` out RAM_ADDR_WIDTH: registered RAM read address.
- `q` in RAM_DATA_WIDTH: RAM read data, valid one cycle after `read_addr`.
- `pix_data` out RAM_DATA_WIDTH: pixel.
- `pix_valid` out 1: pixel available.
- `pix_ready` in 1: sink accepts the pixel.
- `pix_sol` out 1: pixel is first of a line. Qualified by `pix_valid`.
- `pix_eof` out 1: pixel is last of the frame. Qualified by `pix_valid`.

## Operation
- FSM states:
  - IDLE: waits for `start`. `start` goes to RUN and clears all counters.
  - RUN: issues reads. After the last address is issued, goes to DRAIN.
  - DRAIN: no further reads. When the handshake with `pix_eof`=1 completes, goes to DONE.
  - DONE: one cycle, `done`=1, then IDLE.
- Issue rule: a read is issued in a RUN cycle when `occupancy + in_flight ≤ 3`. This uses current register values and gives no credit for a same-cycle pop.
  - Issuing advances `read_addr` by 1 and sets `in_flight` for the next cycle.
  - `read_addr` = BASE_ADDR + issue index. Index runs 0..LINE_WORDS*LINE_COUNT-1, with no wrap within a frame.
- The cycle after each issue, `q` is written into a 4-entry prefetch FIFO. The FIFO never overflows, by construction of the issue rule.
- Output side:
  - `pix_valid` = FIFO not empty.
  - `pix_data` = FIFO head.
  - Pop on `pix_valid && pix_ready`.
  - Column and line counters advance per pop. They drive `pix_sol` (col==0) and `pix_eof` (col==LINE_WORDS-1 and line==LINE_COUNT-1).
- Boundary conditions:
  - `start` while `busy` is ignored.
  - `start` in the DONE cycle is ignored.
  - `reset` at any point: IDLE, FIFO flushed, in-flight read discarded, all outputs to reset values on the next edge.
  - Simultaneous push and pop leaves occupancy unchanged.

## Timing
- Reset values: `busy`=0, `done`=0, `read_addr`=BASE_ADDR, `pix_valid`=0, `pix_data`=0, `pix_sol`=0, `pix_eof`=0.
- Sequence for `start` high in cycle 0:
  - cycle 1: RUN, `read_addr`=BASE_ADDR.
  - cycle 2: `q` carries word 0 and is pushed.
  - cycle 3: `pix_valid`=1 with word 0 and `pix_sol`=1. Start-to-first-pixel latency is 3 cycles.
- With `pix_ready` held high: one pixel per cycle, no bubbles after the first.
  - Last handshake lands in cycle 2+N, where N = LINE_WORDS*LINE_COUNT.
  - `done` is in cycle 3+N; `busy` falls in cycle 4+N.
- Under backpressure (`pix_valid`=1, `pix_ready`=0): `pix_data`, `pix_sol`, `pix_eof` hold stable.
- `pix_valid` never deasserts without a handshake.

## Configuration
- `FRAME_READER_UNDERRUN_EN` defined: adds output `underrun_cnt` [15:0], reset value 0.
  - Cleared on accepted `start`.
  - Increments, saturating at 16'hFFFF, in each RUN/DRAIN cycle with `pix_ready`=1 and `pix_valid`=0, excluding the cycles before the first pixel is available.
- Undefined: no port, no counter logic. All other behaviour is identical.

## Test plan
- Reset then `start`, `pix_ready`=1, LINE_WORDS=4, LINE_COUNT=2, RAM preloaded with word=addr:
  - `read_addr` 0..7 in cycles 1..8.
  - `pix_data` 0..7 in cycles 3..10.
  - `pix_sol` at pixels 0 and 4; `pix_eof` at pixel 7.
  - `done` in cycle 11.
- Same frame, `pix_ready` toggling 1,0,0,1 repeating: all 8 words delivered in order, no duplicates or drops, outputs stable while stalled, FIFO occupancy ≤4.
- `pix_ready`=0 for 20 cycles after `start`: exactly 4 reads issued, `read_addr` frozen at 4. Release delivers 0..7 in order.
- `start` pulsed again in cycle 5 and in the `done` cycle: ignored, single frame only.
- `reset` asserted in cycle 6 mid-frame: next cycle `pix_valid`=0, `busy`=0, `read_addr`=0. A following `start` re-reads from pixel 0.
- With `FRAME_READER_UNDERRUN_EN` and RAM reads throttled by holding `pix_ready`=1 across a frame: `underrun_cnt`=0. Forced stall test (reset mid-stream) leaves the counter at 0 after reset.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// Frame RAM read master: raster-order address walk, 4-deep prefetch FIFO, valid/ready pixel stream.
// Optional FRAME_READER_UNDERRUN_EN adds a saturating underrun_cnt output.
module frame_buffer_reader #(
  parameter int RAM_DATA_WIDTH = 15,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int LINE_WORDS     = 256,
  parameter int LINE_COUNT     = 240,
  parameter int BASE_ADDR      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [RAM_ADDR_WIDTH-1:0] read_addr,
  input  logic [RAM_DATA_WIDTH-1:0] q,
  output logic [RAM_DATA_WIDTH-1:0] pix_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_sol,
  output logic                      pix_eof
`ifdef FRAME_READER_UNDERRUN_EN
  ,
  output logic [15:0]               underrun_cnt
`endif
);

  localparam int N   = LINE_WORDS * LINE_COUNT;
  localparam int IW  = RAM_ADDR_WIDTH + 1;
  localparam int CW  = $clog2(LINE_WORDS);
  localparam int LCW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  localparam logic [IW-1:0]             LAST_IDX  = IW'(N - 1);
  localparam logic [CW-1:0]             LAST_COL  = CW'(LINE_WORDS - 1);
  localparam logic [LCW-1:0]            LAST_LINE = LCW'(LINE_COUNT - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] BASE      = RAM_ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                    state_r;
  logic [IW-1:0]             issue_idx_r;
  logic                      in_flight_r;
  logic [RAM_DATA_WIDTH-1:0] fifo_r [4];
  logic [1:0]                wr_ptr_r;
  logic [1:0]                rd_ptr_r;
  logic [2:0]                occ_r;
  logic [CW-1:0]             col_r;
  logic [LCW-1:0]            line_r;
  logic                      issue_s;
  logic                      pop_s;
  logic                      start_acc_s;

  // Issue/pop decisions and stream outputs, all derived from registered state
  always_comb begin
    start_acc_s = (state_r == ST_IDLE) && start;
    // no credit for a same-cycle pop: occupancy plus the pending read must leave a free slot
    issue_s     = (state_r == ST_RUN) && ((occ_r + 3'(in_flight_r)) <= 3'd3);
    pix_valid   = (occ_r != 3'd0);
    pix_data    = fifo_r[rd_ptr_r];
    pix_sol     = pix_valid && (col_r == '0);
    pix_eof     = pix_valid && (col_r == LAST_COL) && (line_r == LAST_LINE);
    pop_s       = pix_valid && pix_ready;
  end

  // Control FSM: address issue, busy/done flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      read_addr   <= BASE;
      issue_idx_r <= '0;
      in_flight_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done        <= 1'b0;
          in_flight_r <= 1'b0;
          if (start) begin
            state_r     <= ST_RUN;
            busy        <= 1'b1;
            read_addr   <= BASE;
            issue_idx_r <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          in_flight_r <= issue_s;
          if (issue_s) begin
            read_addr   <= read_addr + RAM_ADDR_WIDTH'(1);
            issue_idx_r <= issue_idx_r + IW'(1);
            if (issue_idx_r == LAST_IDX) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          in_flight_r <= 1'b0;
          if (pop_s && pix_eof) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          in_flight_r <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO and raster position counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      occ_r    <= 3'd0;
      col_r    <= '0;
      line_r   <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_r[i] <= '0;
      end
    end else if (start_acc_s) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      occ_r    <= 3'd0;
      col_r    <= '0;
      line_r   <= '0;
    end else begin
      if (in_flight_r) begin
        fifo_r[wr_ptr_r] <= q;
        wr_ptr_r         <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
        if (col_r == LAST_COL) begin
          col_r  <= '0;
          line_r <= (line_r == LAST_LINE) ? '0 : line_r + LCW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      occ_r <= occ_r + 3'(in_flight_r) - 3'(pop_s);
    end
  end

`ifdef FRAME_READER_UNDERRUN_EN
  logic seen_r;

  // Underrun counter: sink ready but no pixel, once the frame has produced its first pixel
  always_ff @(posedge clk) begin
    if (reset || start_acc_s) begin
      underrun_cnt <= 16'd0;
      seen_r       <= 1'b0;
    end else if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
      if (pix_valid) begin
        seen_r <= 1'b1;
      end else begin
        seen_r <= seen_r;
      end
      if (seen_r && pix_ready && !pix_valid && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end else begin
        underrun_cnt <= underrun_cnt;
      end
    end else begin
      underrun_cnt <= underrun_cnt;
      seen_r       <= seen_r;
    end
  end
`endif

endmodule
